neureka_infeat_buffer_loader: RTL and testbench

Write-side controller for the input-feature latch buffer (SCM).
- Accepts a valid/ready stream of DATA_WIDTH words from the streamer.
- Inserts zero words for padded positions and drives the buffer's we/we_all/waddr/wdata/clear write port.
- Tracks buffer ownership (LOAD → SETTLE → FULL) so the downstream PE array reads the flat buffer only when contents are stable.

---
 rtl/neureka_infeat_buffer_loader.sv | 167 ++++++++++++++++
 tb/tb_neureka_infeat_buffer_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neureka_infeat_buffer_loader.sv
// Write-side controller for the input-feature latch buffer.
// Streams words into the buffer, inserts zeros for padded positions and
// tracks buffer ownership so the PE array only reads stable contents.
module neureka_infeat_buffer_loader #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned NUM_WORDS  = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH:0]   nb_words_i,
   input  logic [NUM_WORDS-1:0]  pad_mask_i,
   input  logic                  release_i,
   input  logic                  in_valid_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  in_ready_o,
   output logic                  buf_we_o,
   output logic                  buf_we_all_o,
   output logic                  buf_clear_o,
   output logic [ADDR_WIDTH-1:0] buf_waddr_o,
   output logic [DATA_WIDTH-1:0] buf_wdata_o,
   output logic                  busy_o,
   output logic                  full_o,
   output logic                  done_o
);

   localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BCAST  = 3'd1,
      LOAD   = 3'd2,
      SETTLE = 3'd3,
      FULL   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  nb_q, nb_d;
   logic [CNT_WIDTH-1:0]  nb_eff;
   logic [NUM_WORDS-1:0]  pad_q, pad_d;
   logic [1:0]            settle_q, settle_d;
   logic                  busy_q, full_q, done_q;

   logic                  all_pad;
   logic                  pad_cur;
   logic                  in_load;
   logic                  beat;
   logic                  wr;
   logic                  last_word;
   logic                  start_ok;

   // Out-of-range word counts (0 or above the buffer depth) mean a full load
   always_comb begin
      nb_eff = nb_words_i;
      if (nb_words_i == '0 || nb_words_i > CNT_WIDTH'(NUM_WORDS)) begin
         nb_eff = CNT_WIDTH'(NUM_WORDS);
      end
   end

   // A load whose every requested word is padded collapses into one broadcast
   always_comb begin
      all_pad = 1'b1;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         if (CNT_WIDTH'(i) < nb_eff && !pad_mask_i[i]) begin
            all_pad = 1'b0;
         end
      end
   end

   // Per-cycle decode of the current word and the handshake
   always_comb begin
      in_load   = (state_q == LOAD) && !clear_i;
      pad_cur   = pad_q[cnt_q[ADDR_WIDTH-1:0]];
      beat      = in_load && !pad_cur && in_valid_i;
      wr        = in_load && (pad_cur || in_valid_i);
      last_word = (cnt_q == nb_q - CNT_WIDTH'(1));
      start_ok  = start_i && (state_q == IDLE || state_q == FULL);
   end

   // Buffer write port, combinational so the buffer sees the word in the same cycle
   always_comb begin
      in_ready_o   = in_load && !pad_cur;
      buf_clear_o  = clear_i;
      buf_we_o     = wr;
      buf_we_all_o = (state_q == BCAST) && !clear_i;
      buf_waddr_o  = wr ? cnt_q[ADDR_WIDTH-1:0] : '0;
      buf_wdata_o  = beat ? in_data_i : '0;
   end

   // Next-state and counter update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      nb_d     = nb_q;
      pad_d    = pad_q;
      settle_d = settle_q;
      if (clear_i) begin
         state_d  = IDLE;
         cnt_d    = '0;
         settle_d = '0;
      end else begin
         case (state_q)
            IDLE, FULL: begin
               if (start_ok) begin
                  nb_d    = nb_eff;
                  pad_d   = pad_mask_i;
                  cnt_d   = '0;
                  state_d = all_pad ? BCAST : LOAD;
               end else if (state_q == FULL && release_i) begin
                  state_d = IDLE;
               end
            end
            BCAST: begin
               state_d  = SETTLE;
               settle_d = '0;
            end
            LOAD: begin
               if (wr) begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
                  if (last_word) begin
                     state_d  = SETTLE;
                     settle_d = '0;
                  end
               end
            end
            SETTLE: begin
               settle_d = settle_q + 2'd1;
               if (settle_q == 2'd1) begin
                  state_d = FULL;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, counters and registered status outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         nb_q     <= '0;
         pad_q    <= '0;
         settle_q <= '0;
         busy_q   <= 1'b0;
         full_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         nb_q     <= nb_d;
         pad_q    <= pad_d;
         settle_q <= settle_d;
         busy_q   <= (state_d == LOAD) || (state_d == SETTLE);
         full_q   <= (state_d == FULL);
         done_q   <= (state_d == FULL) && (state_q != FULL);
      end
   end

   assign busy_o = busy_q;
   assign full_o = full_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_neureka_infeat_buffer_loader.sv
// Self-checking bench: a behavioural model of each load (word order, padding,
// handshake count, FULL latency) is checked against an emulated buffer.
module tb_neureka_infeat_buffer_loader;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 128;
   localparam int unsigned NW = 64;
   localparam int unsigned CW = AW + 1;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          clear_i, start_i, release_i, in_valid_i;
   logic [CW-1:0] nb_words_i;
   logic [NW-1:0] pad_mask_i;
   logic [DW-1:0] in_data_i;
   logic          in_ready_o, buf_we_o, buf_we_all_o, buf_clear_o;
   logic [AW-1:0] buf_waddr_o;
   logic [DW-1:0] buf_wdata_o;
   logic          busy_o, full_o, done_o;

   always #5 clk_i = ~clk_i;

   neureka_infeat_buffer_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
      .nb_words_i(nb_words_i), .pad_mask_i(pad_mask_i), .release_i(release_i),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
      .buf_we_o(buf_we_o), .buf_we_all_o(buf_we_all_o), .buf_clear_o(buf_clear_o),
      .buf_waddr_o(buf_waddr_o), .buf_wdata_o(buf_wdata_o),
      .busy_o(busy_o), .full_o(full_o), .done_o(done_o));

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] mem_tb  [NW];
   logic [DW-1:0] exp_mem [NW];
   int            wr_cnt  [NW];
   int            we_all_cnt, hs_cnt, done_cnt;
   logic [DW-1:0] beats [$];

   function automatic logic [DW-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle_inputs();
      clear_i = 1'b0; start_i = 1'b0; release_i = 1'b0; in_valid_i = 1'b0;
      nb_words_i = '0; pad_mask_i = '0; in_data_i = '0;
   endtask

   // Emulated buffer plus per-cycle invariants, called once per cycle at sample time
   task automatic observe();
      n_checks++;
      if (buf_we_o && buf_we_all_o) begin
         n_fail++; $display("FAIL we_exclusive: we=%b we_all=%b required not both 1", buf_we_o, buf_we_all_o);
      end
      n_checks++;
      if (in_ready_o && !busy_o) begin
         n_fail++; $display("FAIL ready_outside_load: in_ready=1 busy=%b required in_ready=0", busy_o);
      end
      if (in_valid_i && in_ready_o) hs_cnt++;
      if (done_o) done_cnt++;
      if (buf_clear_o) begin
         for (int i = 0; i < NW; i++) mem_tb[i] = '0;
      end else if (buf_we_all_o) begin
         for (int i = 0; i < NW; i++) mem_tb[i] = '0;
         we_all_cnt++;
      end else if (buf_we_o) begin
         mem_tb[buf_waddr_o] = buf_wdata_o;
         wr_cnt[buf_waddr_o]++;
      end
   endtask

   // One full load: model computes expected contents, handshakes and FULL latency
   task automatic run_load(input int nb_in, input logic [NW-1:0] pad_in, input bit [1023:0] vld,
                           input bit rel_with_start, input bit spur);
      int            nb_eff, nreal, t, lat, j, c, bidx, bad_wr, bad_mem, first_bad;
      bit            allpad, full_seen;
      logic [DW-1:0] exp_new [NW];
      nb_eff = (nb_in == 0 || nb_in > NW) ? NW : nb_in;
      allpad = 1'b1; nreal = 0;
      for (int i = 0; i < nb_eff; i++) if (!pad_in[i]) begin allpad = 1'b0; nreal++; end
      while (beats.size() < nreal) beats.push_back(rand_word());
      for (int i = 0; i < NW; i++) exp_new[i] = exp_mem[i];
      if (allpad) begin
         t = 1;
         for (int i = 0; i < NW; i++) exp_new[i] = '0;
      end else begin
         t = 0; j = 0;
         for (int i = 0; i < nb_eff; i++) begin
            if (pad_in[i]) begin
               t++; exp_new[i] = '0;
            end else begin
               while (t < 1023 && !vld[t]) t++;
               t++; exp_new[i] = beats[j]; j++;
            end
         end
      end
      lat = t + 3;

      for (int i = 0; i < NW; i++) wr_cnt[i] = 0;
      we_all_cnt = 0; hs_cnt = 0; done_cnt = 0; bidx = 0;

      @(negedge clk_i);
      start_i = 1'b1; nb_words_i = CW'(nb_in); pad_mask_i = pad_in;
      release_i = rel_with_start; in_valid_i = 1'($urandom); in_data_i = rand_word();
      #1 observe();

      full_seen = 1'b0; c = 0;
      while (!full_seen && c < lat + 20) begin
         c++;
         @(negedge clk_i);
         start_i    = (spur && c < lat) ? 1'($urandom) : 1'b0;
         release_i  = (c < lat) ? 1'($urandom) : 1'b0;
         in_valid_i = (c - 1 < 1024) ? vld[c-1] : 1'b1;
         in_data_i  = (bidx < beats.size()) ? beats[bidx] : rand_word();
         #1 observe();
         if (in_valid_i && in_ready_o) bidx++;
         if (c == 1 && rel_with_start && !allpad) begin
            n_checks++;
            if (busy_o !== 1'b1 || full_o !== 1'b0) begin
               n_fail++; $display("FAIL start_over_release: busy=%b full=%b required busy=1 full=0", busy_o, full_o);
            end
         end
         if (full_o === 1'b1) full_seen = 1'b1;
      end
      n_checks++;
      if (!full_seen || c != lat) begin
         n_fail++; $display("FAIL full_latency nb=%0d: got cycle %0d (seen=%b) required %0d", nb_in, c, full_seen, lat);
      end
      n_checks++;
      if (done_o !== 1'b1) begin
         n_fail++; $display("FAIL done_on_entry: got %b required 1", done_o);
      end

      @(negedge clk_i);
      start_i = 1'b0; release_i = 1'b0; in_valid_i = 1'($urandom); in_data_i = rand_word();
      #1 observe();
      n_checks++;
      if (full_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++; $display("FAIL full_hold: full=%b done=%b busy=%b required 1 0 0", full_o, done_o, busy_o);
      end
      n_checks++;
      if (done_cnt != 1) begin
         n_fail++; $display("FAIL done_count: got %0d required 1", done_cnt);
      end
      n_checks++;
      if (hs_cnt != nreal) begin
         n_fail++; $display("FAIL handshakes nb=%0d: got %0d required %0d", nb_in, hs_cnt, nreal);
      end
      n_checks++;
      if (we_all_cnt != (allpad ? 1 : 0)) begin
         n_fail++; $display("FAIL broadcast_count: got %0d required %0d", we_all_cnt, allpad ? 1 : 0);
      end
      bad_wr = 0;
      for (int i = 0; i < NW; i++) if (wr_cnt[i] != ((!allpad && i < nb_eff) ? 1 : 0)) bad_wr++;
      n_checks++;
      if (bad_wr != 0) begin
         n_fail++; $display("FAIL writes_per_index: %0d indices wrong, required 0", bad_wr);
      end
      bad_mem = 0; first_bad = -1;
      for (int i = 0; i < NW; i++) if (mem_tb[i] !== exp_new[i]) begin
         bad_mem++; if (first_bad < 0) first_bad = i;
      end
      n_checks++;
      if (bad_mem != 0) begin
         n_fail++;
         $display("FAIL buffer_contents: %0d words wrong, first word %0d got %h required %h",
                  bad_mem, first_bad, mem_tb[first_bad], exp_new[first_bad]);
      end
      for (int i = 0; i < NW; i++) exp_mem[i] = exp_new[i];
      beats.delete();
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; start_i = 1'b1; in_valid_i = 1'b1; nb_words_i = CW'(5);
      #12;
      n_checks++;
      if ({in_ready_o, buf_we_o, buf_we_all_o, buf_clear_o, busy_o, full_o, done_o} !== 7'b0 ||
          buf_waddr_o !== '0 || buf_wdata_o !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %b/%h/%h required all zero",
            {in_ready_o, buf_we_o, buf_we_all_o, buf_clear_o, busy_o, full_o, done_o}, buf_waddr_o, buf_wdata_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1; idle_inputs(); in_valid_i = 1'b1;
      @(negedge clk_i);
      #1 observe();
      n_checks++;
      if (busy_o !== 1'b0 || full_o !== 1'b0 || in_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: busy=%b full=%b ready=%b required 0 0 0", busy_o, full_o, in_ready_o);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 4; i++) beats.push_back(DW'(8'hA0 + i));
      run_load(4, '0, '1, 1'b0, 1'b0);
   endtask

   task automatic test_padding();
      run_load(6, NW'(6'b100101), '1, 1'b0, 1'b0);
   endtask

   task automatic test_bcast();
      run_load(64, '1, '1, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      bit [1023:0] v;
      v = '1; v[1] = 1'b0; v[2] = 1'b0;
      run_load(3, '0, v, 1'b0, 1'b1);
   endtask

   task automatic test_clear();
      @(negedge clk_i);
      start_i = 1'b1; nb_words_i = CW'(8); pad_mask_i = '0; in_valid_i = 1'b0;
      #1 observe();
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk_i);
         start_i = 1'b0; in_valid_i = 1'b1; in_data_i = rand_word();
         #1 observe();
      end
      @(negedge clk_i);
      clear_i = 1'b1; in_valid_i = 1'b1;
      #1 observe();
      n_checks++;
      if (buf_clear_o !== 1'b1 || buf_we_o !== 1'b0 || buf_we_all_o !== 1'b0 || in_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL clear_cycle: clear=%b we=%b we_all=%b ready=%b required 1 0 0 0",
            buf_clear_o, buf_we_o, buf_we_all_o, in_ready_o);
      end
      @(negedge clk_i);
      clear_i = 1'b0;
      #1 observe();
      n_checks++;
      if (busy_o !== 1'b0 || full_o !== 1'b0 || in_ready_o !== 1'b0 || buf_clear_o !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_clear: busy=%b full=%b ready=%b clear=%b required 0 0 0 0",
            busy_o, full_o, in_ready_o, buf_clear_o);
      end
      for (int i = 0; i < NW; i++) exp_mem[i] = '0;
      run_load(8, '0, '1, 1'b0, 1'b0);
   endtask

   task automatic test_release_start();
      run_load(5, '0, '1, 1'b1, 1'b0);
   endtask

   task automatic test_release();
      @(negedge clk_i);
      release_i = 1'b1;
      #1 observe();
      @(negedge clk_i);
      release_i = 1'b0;
      #1 observe();
      n_checks++;
      if (full_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++; $display("FAIL release: full=%b busy=%b done=%b required 0 0 0", full_o, busy_o, done_o);
      end
   endtask

   task automatic test_boundaries();
      run_load(0, '1, '1, 1'b0, 1'b0);
      run_load(100, {$urandom, $urandom} & {$urandom, $urandom}, '1, 1'b0, 1'b0);
      run_load(1, '0, '1, 1'b0, 1'b0);
      run_load(2, NW'(2'b11), '1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_load();
      bit [1023:0] v;
      @(negedge clk_i);
      start_i = 1'b1; nb_words_i = CW'(16); pad_mask_i = '0; in_valid_i = 1'b1;
      #1 observe();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk_i);
         start_i = 1'b0; in_data_i = rand_word();
         #1 observe();
      end
      @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      n_checks++;
      if (busy_o !== 1'b0 || in_ready_o !== 1'b0 || buf_we_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_load: busy=%b ready=%b we=%b required 0 0 0", busy_o, in_ready_o, buf_we_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1; idle_inputs();
      for (int i = 0; i < 1024; i++) v[i] = ($urandom_range(0, 3) != 0);
      run_load(64, {$urandom, $urandom} & {$urandom, $urandom}, v, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      bit [1023:0]   v;
      logic [NW-1:0] p;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 1024; i++) v[i] = ($urandom_range(0, 3) != 0);
         p = (k == 3) ? '1 : ({$urandom, $urandom} & {$urandom, $urandom});
         run_load(int'($urandom_range(0, 80)), p, v, 1'($urandom), 1'b1);
      end
   endtask

   initial begin
      idle_inputs();
      rst_ni = 1'b0;
      for (int i = 0; i < NW; i++) begin mem_tb[i] = '0; exp_mem[i] = '0; wr_cnt[i] = 0; end
      test_reset();
      test_basic();
      test_padding();
      test_bcast();
      test_backpressure();
      test_clear();
      test_release_start();
      test_release();
      test_boundaries();
      test_reset_mid_load();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
